mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arb.sv | 181 ++++++++++++++++++
 tb/tb_mem_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the external-memory arbiter: channel indices, address regions,
// FSM encoding and watchdog limits.
package mem_arb_pkg;

  localparam int unsigned NumCh = 4;
  localparam int unsigned ExtAw = 23;

  // Channel indices double as request/grant bit positions.
  localparam logic [1:0] ChCrom   = 2'd0;
  localparam logic [1:0] ChProm   = 2'd1;
  localparam logic [1:0] ChChrram = 2'd2;
  localparam logic [1:0] ChPrgram = 2'd3;

  // Region codes placed in extaddr[22:21].
  localparam logic [1:0] RegionProm   = 2'b00;
  localparam logic [1:0] RegionCrom   = 2'b01;
  localparam logic [1:0] RegionChrram = 2'b10;
  localparam logic [1:0] RegionPrgram = 2'b11;

  localparam logic [7:0] WdogLimit   = 8'hFF;
  localparam logic [7:0] TimeoutData = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAck,
    StHold
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NumCh-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Rotating-priority picker: first asserted request at or after ptr (wrapping) wins.
// With ptr tied to 0 this degenerates to fixed priority crom > prom > chrram > prgram.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NumCh-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NumCh-1:0] grant
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Four-channel arbiter onto a shared external byte memory with a per-transaction watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; fixed priority when undefined.
module mem_arb
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic [20:0] promaddr,
  input  logic        promreq,
  output logic        promack,
  output logic [7:0]  promdata,

  input  logic [20:0] cromaddr,
  input  logic        cromreq,
  output logic        cromack,
  output logic [7:0]  cromdata,

  input  logic [12:0] chrramaddr,
  input  logic [7:0]  chrramwdata,
  input  logic        chrramwr,
  input  logic        chrramreq,
  output logic        chrramack,
  output logic [7:0]  chrramrdata,

  input  logic [14:0] prgramaddr,
  input  logic [7:0]  prgramwdata,
  input  logic        prgramwr,
  input  logic        prgramreq,
  output logic        prgramack,
  output logic [7:0]  prgramrdata,

  output logic [22:0] extaddr,
  output logic [7:0]  extwdata,
  output logic        extwr,
  output logic        extreq,
  input  logic        extack,
  input  logic [7:0]  extrdata,

  output logic        timeout
);

  state_e state_q, state_d;

  logic [NumCh-1:0]      req_vec;
  logic [NumCh-1:0]      pick_gnt;
  logic [1:0]            pick_idx;
  logic [1:0]            ptr;
  logic [1:0]            gnt_q;
  logic [ExtAw-1:0]      sel_addr, extaddr_q;
  logic [7:0]            sel_wdata, extwdata_q;
  logic                  sel_wr, extwr_q;
  logic [7:0]            wdog_q;
  logic [NumCh-1:0][7:0] data_q;
  logic                  timeout_q;
  logic                  start;
  logic                  wdog_expire;
  logic [NumCh-1:0]      ack_vec;

  assign req_vec = {prgramreq, chrramreq, promreq, cromreq};

  mem_arb_pick u_pick (
    .req   (req_vec),
    .ptr   (ptr),
    .grant (pick_gnt)
  );

  assign pick_idx = onehot_to_idx(pick_gnt);
  assign start    = (state_q == StIdle) && (|req_vec);

  // Last BUSY cycle before the counter would reach the limit.
  assign wdog_expire = (state_q == StBusy) && !extack && (wdog_q == WdogLimit - 8'd1);

`ifdef MEM_ARB_RR_EN
  logic [1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= ChCrom;
    end else if (start) begin
      ptr_q <= pick_idx + 2'd1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = ChCrom;
`endif

  // Channel address zero-extended under its region code; ROM channels never write.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    unique case (pick_idx)
      ChCrom:   sel_addr = {RegionCrom, cromaddr};
      ChProm:   sel_addr = {RegionProm, promaddr};
      ChChrram: begin
        sel_addr  = {RegionChrram, 8'b0, chrramaddr};
        sel_wdata = chrramwdata;
        sel_wr    = chrramwr;
      end
      ChPrgram: begin
        sel_addr  = {RegionPrgram, 6'b0, prgramaddr};
        sel_wdata = prgramwdata;
        sel_wr    = prgramwr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req_vec) state_d = StBusy;
      StBusy:  if (extack || wdog_expire) state_d = StAck;
      StAck:   state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_vec = '0;
    extreq  = (state_q == StBusy);
    if (state_q == StAck) ack_vec[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= ChCrom;
      extaddr_q  <= '0;
      extwdata_q <= '0;
      extwr_q    <= 1'b0;
      wdog_q     <= '0;
      data_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (start) begin
        gnt_q      <= pick_idx;
        extaddr_q  <= sel_addr;
        extwdata_q <= sel_wdata;
        extwr_q    <= sel_wr;
        wdog_q     <= '0;
      end
      if (state_q == StBusy) begin
        if (extack) begin
          if (!extwr_q) data_q[gnt_q] <= extrdata;
        end else begin
          wdog_q <= wdog_q + 8'd1;
          if (wdog_expire) begin
            timeout_q <= 1'b1;
            if (!extwr_q) data_q[gnt_q] <= TimeoutData;
          end
        end
      end
    end
  end

  assign cromack     = ack_vec[ChCrom];
  assign promack     = ack_vec[ChProm];
  assign chrramack   = ack_vec[ChChrram];
  assign prgramack   = ack_vec[ChPrgram];
  assign cromdata    = data_q[ChCrom];
  assign promdata    = data_q[ChProm];
  assign chrramrdata = data_q[ChChrram];
  assign prgramrdata = data_q[ChPrgram];
  assign extaddr     = extaddr_q;
  assign extwdata    = extwdata_q;
  assign extwr       = extwr_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: table of single transactions plus contention, watchdog,
// reset-abort and stray-extack sequences. Channel ids: 0 crom, 1 prom, 2 chrram, 3 prgram.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] promaddr, cromaddr;
  logic        promreq, cromreq, promack, cromack;
  logic [7:0]  promdata, cromdata;
  logic [12:0] chrramaddr;
  logic [7:0]  chrramwdata, chrramrdata;
  logic        chrramwr, chrramreq, chrramack;
  logic [14:0] prgramaddr;
  logic [7:0]  prgramwdata, prgramrdata;
  logic        prgramwr, prgramreq, prgramack;
  logic [22:0] extaddr;
  logic [7:0]  extwdata, extrdata;
  logic        extwr, extreq, extack, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk         (clk),
    .reset       (reset),
    .promaddr    (promaddr),
    .promreq     (promreq),
    .promack     (promack),
    .promdata    (promdata),
    .cromaddr    (cromaddr),
    .cromreq     (cromreq),
    .cromack     (cromack),
    .cromdata    (cromdata),
    .chrramaddr  (chrramaddr),
    .chrramwdata (chrramwdata),
    .chrramwr    (chrramwr),
    .chrramreq   (chrramreq),
    .chrramack   (chrramack),
    .chrramrdata (chrramrdata),
    .prgramaddr  (prgramaddr),
    .prgramwdata (prgramwdata),
    .prgramwr    (prgramwr),
    .prgramreq   (prgramreq),
    .prgramack   (prgramack),
    .prgramrdata (prgramrdata),
    .extaddr     (extaddr),
    .extwdata    (extwdata),
    .extwr       (extwr),
    .extreq      (extreq),
    .extack      (extack),
    .extrdata    (extrdata),
    .timeout     (timeout)
  );

  typedef struct {
    int          ch;
    logic [20:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic [7:0]  rdata;
    logic [22:0] exp_addr;
    logic        exp_wr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int ch);
    case (ch)
      0:       return cromack;
      1:       return promack;
      2:       return chrramack;
      default: return prgramack;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input int ch);
    case (ch)
      0:       return cromdata;
      1:       return promdata;
      2:       return chrramrdata;
      default: return prgramrdata;
    endcase
  endfunction

  task automatic set_req(input int ch, input logic r);
    case (ch)
      0:       cromreq   = r;
      1:       promreq   = r;
      2:       chrramreq = r;
      default: prgramreq = r;
    endcase
  endtask

  task automatic drive(input int ch, input logic [20:0] a, input logic [7:0] wd, input logic w);
    case (ch)
      0: cromaddr = a;
      1: promaddr = a;
      2: begin chrramaddr = a[12:0]; chrramwdata = wd; chrramwr = w; end
      default: begin prgramaddr = a[14:0]; prgramwdata = wd; prgramwr = w; end
    endcase
    set_req(ch, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction; memory acks in the first cycle it sees extreq. Counting the request
  // cycle as cycle 1, the ack must be visible in cycle 3, i.e. two edges after the request.
  task automatic run_txn(input vec_t v, input string tag);
    int          cyc = 0;
    bit          got = 0;
    bit          seen = 0;
    logic [22:0] s_addr = 'x;
    logic [7:0]  s_wdata = 'x;
    logic        s_wr = 1'bx;
    drive(v.ch, v.addr, v.wdata, v.wr);
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (extreq) begin
        if (!seen) begin
          s_addr = extaddr; s_wdata = extwdata; s_wr = extwr; seen = 1;
        end
        extack   = 1'b1;
        extrdata = v.rdata;
      end else begin
        extack = 1'b0;
      end
      if (ack_of(v.ch)) got = 1;
    end
    set_req(v.ch, 1'b0);
    check({tag, " ack_latency"}, 32'(cyc), 32'd2);
    check({tag, " extaddr"}, 32'(s_addr), 32'(v.exp_addr));
    check({tag, " extwr"}, 32'(s_wr), 32'(v.exp_wr));
    check({tag, " extwdata"}, 32'(s_wdata), 32'(v.exp_wdata));
    check({tag, " rdata"}, 32'(data_of(v.ch)), 32'(v.exp_data));
    tick();
    extack = 1'b0;
    check({tag, " ack_pulse"}, 32'(ack_of(v.ch)), 32'd0);
    tick();
  endtask

  task automatic contention_once();
    int crom_at = -1;
    int prom_at = -1;
    drive(0, 21'h00100, 8'h00, 1'b0);
    drive(1, 21'h00200, 8'h00, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      extack   = extreq;
      extrdata = 8'h30 + 8'(c);
      if (cromack) begin crom_at = c; set_req(0, 1'b0); end
      if (promack) begin prom_at = c; set_req(1, 1'b0); end
    end
    extack = 1'b0;
    check("contend crom_ack_cycle", 32'(crom_at), 32'd2);
    check("contend prom_ack_cycle", 32'(prom_at), 32'd6);
    check("contend cromdata", 32'(cromdata), 32'h31);
    check("contend promdata", 32'(promdata), 32'h35);
  endtask

  // Both requesters re-request the cycle after each ack; records the first three winners.
  task automatic contention_repeat();
    int   n = 0;
    int   order[3] = '{-1, -1, -1};
    logic drop_c = 1'b0;
    logic drop_p = 1'b0;
    drive(0, 21'h00010, 8'h00, 1'b0);
    drive(1, 21'h00020, 8'h00, 1'b0);
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      extack   = extreq;
      extrdata = 8'h5A;
      if (drop_c) begin set_req(0, 1'b1); drop_c = 1'b0; end
      if (drop_p) begin set_req(1, 1'b1); drop_p = 1'b0; end
      if (cromack) begin order[n] = 0; n++; set_req(0, 1'b0); drop_c = 1'b1; end
      if (promack) begin order[n] = 1; n++; set_req(1, 1'b0); drop_p = 1'b1; end
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    tick();
    extack = 1'b0;
    tick();
    tick();
`ifdef MEM_ARB_RR_EN
    check("repeat grant0", 32'(order[0]), 32'd0);
    check("repeat grant1", 32'(order[1]), 32'd1);
    check("repeat grant2", 32'(order[2]), 32'd0);
`else
    check("repeat grant0", 32'(order[0]), 32'd0);
    check("repeat grant1", 32'(order[1]), 32'd0);
    check("repeat grant2", 32'(order[2]), 32'd0);
`endif
  endtask

  task automatic watchdog_seq();
    int busy = 0;
    bit got = 0;
    extack = 1'b0;
    drive(1, 21'h0ABCD, 8'h00, 1'b0);
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      if (extreq) begin
        busy++;
        if (busy == 254) check("wdog timeout_early", 32'(timeout), 32'd0);
      end
      if (promack) got = 1;
    end
    set_req(1, 1'b0);
    check("wdog acked", 32'(got), 32'd1);
    check("wdog busy_cycles", 32'(busy), 32'd255);
    check("wdog promdata", 32'(promdata), 32'hFF);
    check("wdog timeout_set", 32'(timeout), 32'd1);
    check("wdog extaddr", 32'(extaddr), 32'h000ABCD);
    tick();
    tick();
    tick();
    check("wdog timeout_sticky", 32'(timeout), 32'd1);
  endtask

  task automatic reset_and_stray_seq();
    bit any_ack = 0;
    drive(0, 21'h00001, 8'h00, 1'b0);
    tick();
    check("rstbusy extreq_before", 32'(extreq), 32'd1);
    reset = 1'b1;
    set_req(0, 1'b0);
    tick();
    check("rstbusy extreq", 32'(extreq), 32'd0);
    check("rstbusy cromack", 32'(cromack), 32'd0);
    check("rstbusy timeout", 32'(timeout), 32'd0);
    check("rstbusy promdata", 32'(promdata), 32'h00);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cromack || promack || chrramack || prgramack || extreq) any_ack = 1;
    end
    check("rstbusy no_ack_after", 32'(any_ack), 32'd0);
    extack   = 1'b1;
    extrdata = 8'h99;
    any_ack  = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cromack || promack || chrramack || prgramack || extreq) any_ack = 1;
    end
    extack = 1'b0;
    check("stray no_ack", 32'(any_ack), 32'd0);
    check("stray cromdata", 32'(cromdata), 32'h00);
    check("stray chrramrdata", 32'(chrramrdata), 32'h00);
  endtask

  initial begin
    vec_t after_rst;
    reset       = 1'b1;
    promaddr    = '0; promreq   = 1'b0;
    cromaddr    = '0; cromreq   = 1'b0;
    chrramaddr  = '0; chrramwdata = '0; chrramwr = 1'b0; chrramreq = 1'b0;
    prgramaddr  = '0; prgramwdata = '0; prgramwr = 1'b0; prgramreq = 1'b0;
    extack      = 1'b0; extrdata = '0;

    //          ch addr        wdata  wr  rdata  exp_addr      wr  wdata  data
    vecs[0] = '{1, 21'h12345,  8'h00, 0, 8'hA5, 23'h0012345, 0, 8'h00, 8'hA5};
    vecs[1] = '{0, 21'h1FFFFF, 8'h00, 0, 8'h5A, 23'h03FFFFF, 0, 8'h00, 8'h5A};
    vecs[2] = '{2, 21'h00123,  8'h00, 0, 8'h77, 23'h0400123, 0, 8'h00, 8'h77};
    vecs[3] = '{2, 21'h01ABC,  8'h3C, 1, 8'hEE, 23'h0401ABC, 1, 8'h3C, 8'h77};
    vecs[4] = '{3, 21'h07FFF,  8'h00, 0, 8'h81, 23'h0607FFF, 0, 8'h00, 8'h81};
    vecs[5] = '{3, 21'h00000,  8'hC3, 1, 8'h11, 23'h0600000, 1, 8'hC3, 8'h81};
    vecs[6] = '{1, 21'h00000,  8'h00, 0, 8'h00, 23'h0000000, 0, 8'h00, 8'h00};

    repeat (3) tick();
    check("reset extreq", 32'(extreq), 32'd0);
    check("reset extwr", 32'(extwr), 32'd0);
    check("reset extaddr", 32'(extaddr), 32'd0);
    check("reset extwdata", 32'(extwdata), 32'd0);
    check("reset acks", 32'({cromack, promack, chrramack, prgramack}), 32'd0);
    check("reset data", 32'({cromdata, promdata, chrramrdata, prgramrdata}), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    contention_once();
    contention_repeat();
    watchdog_seq();
    reset_and_stray_seq();

    after_rst = '{3, 21'h00042, 8'h00, 0, 8'h6B, 23'h0600042, 0, 8'h00, 8'h6B};
    run_txn(after_rst, "post_reset");
    check("post_reset timeout", 32'(timeout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
